// File: rtl/rv_csr_exec_if.sv
// rtl/rv_csr_exec_if.sv - request, response and CSR-file port bundle for rv_csr_exec
//
// Purpose: groups every non-clock signal of rv_csr_exec.
// Ports:
//   req_*   : request channel (valid/ready), decoded Zicsr instruction fields
//   csr_*   : CSR file registered read port and write port
//   rsp_*   : response channel (valid/ready), old CSR value for rd writeback
// Modports:
//   slave  : the execution stage (rv_csr_exec)
//   master : the environment (issue logic, CSR file, writeback consumer)
interface rv_csr_exec_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TID_WIDTH  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_csr_addr;
  logic [4:0]            req_rs1_idx;
  logic [DATA_WIDTH-1:0] req_rs1_val;
  logic [4:0]            req_rd;
  logic [TID_WIDTH-1:0]  req_tid;

  logic [ADDR_WIDTH-1:0] csr_raddr;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic [ADDR_WIDTH-1:0] csr_waddr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  csr_wr;
  logic                  csr_en;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [4:0]            rsp_rd;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TID_WIDTH-1:0]  rsp_tid;
  logic                  rsp_illegal;

  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_val, req_rd, req_tid,
    output req_ready,
    output csr_raddr, csr_waddr, csr_wdata, csr_wr, csr_en,
    input  csr_rdata,
    output rsp_valid, rsp_rd, rsp_we, rsp_data, rsp_tid, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_idx, req_rs1_val, req_rd, req_tid,
    input  req_ready,
    input  csr_raddr, csr_waddr, csr_wdata, csr_wr, csr_en,
    output csr_rdata,
    input  rsp_valid, rsp_rd, rsp_we, rsp_data, rsp_tid, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/rv_csr_exec.sv
// rtl/rv_csr_exec.sv - Zicsr read-modify-write execution stage in front of the CSR file
//
// Purpose: accepts one CSRRW/RS/RC(I) instruction at a time, reads the CSR through the
//   file's 1-cycle registered read port, writes the updated value back, and returns the
//   old value tagged with the issuing thread.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rv_csr_exec_if.slave (req_*, csr_*, rsp_* channels)
// Configuration:
//   RV_CSR_EXEC_ILLEGAL_EN : when defined, writes to read-only CSRs (addr[11:10]==2'b11)
//   and funct3 000/100 are flagged on rsp_illegal and suppress the CSR write.
module rv_csr_exec #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TID_WIDTH  = 3
) (
  input logic           clk,
  input logic           rst,
  rv_csr_exec_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CALC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            rs1_idx_q, rs1_idx_d;
  logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d;
  logic [4:0]            rd_q, rd_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;
  logic                  csr_wr_q, csr_wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TID_WIDTH-1:0]  rsp_tid_q, rsp_tid_d;
  logic                  rsp_illegal_q, rsp_illegal_d;

  // Decode of the latched instruction; funct3[1:0]==0 is the reserved no-op encoding.
  logic [1:0]            kind;
  logic                  is_nop;
  logic                  wr_attempt;
  logic                  illegal;
  logic                  do_write;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] new_val;

  always_comb begin
    kind       = funct3_q[1:0];
    is_nop     = (kind == 2'd0);
    operand    = funct3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    // RW always writes; RS/RC with rs1 field 0 are pure reads.
    wr_attempt = (kind == 2'd1) || (kind[1] && (rs1_idx_q != 5'd0));
`ifdef RV_CSR_EXEC_ILLEGAL_EN
    illegal    = is_nop || (wr_attempt && (addr_q[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11));
`else
    illegal    = 1'b0;
`endif
    do_write   = wr_attempt && !illegal;
    case (kind)
      2'd1:    new_val = operand;
      2'd2:    new_val = bus.csr_rdata | operand;
      2'd3:    new_val = bus.csr_rdata & ~operand;
      default: new_val = bus.csr_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    addr_d        = addr_q;
    rs1_idx_d     = rs1_idx_q;
    rs1_val_d     = rs1_val_q;
    rd_d          = rd_q;
    tid_d         = tid_q;
    csr_wr_d      = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_we_d      = rsp_we_q;
    rsp_data_d    = rsp_data_q;
    rsp_tid_d     = rsp_tid_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          funct3_d  = bus.req_funct3;
          addr_d    = bus.req_csr_addr;
          rs1_idx_d = bus.req_rs1_idx;
          rs1_val_d = bus.req_rs1_val;
          rd_d      = bus.req_rd;
          tid_d     = bus.req_tid;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        // The write decision does not depend on the read data, so the strobe can be
        // registered here and be high for exactly the CALC cycle.
        csr_wr_d = do_write;
        state_d  = S_CALC;
      end
      S_CALC: begin
        rsp_valid_d   = 1'b1;
        rsp_rd_d      = rd_q;
        rsp_tid_d     = tid_q;
        rsp_illegal_d = illegal;
        rsp_we_d      = (rd_q != 5'd0) && !illegal && !is_nop;
        rsp_data_d    = is_nop ? '0 : bus.csr_rdata;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      funct3_q      <= '0;
      addr_q        <= '0;
      rs1_idx_q     <= '0;
      rs1_val_q     <= '0;
      rd_q          <= '0;
      tid_q         <= '0;
      csr_wr_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_we_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tid_q     <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      addr_q        <= addr_d;
      rs1_idx_q     <= rs1_idx_d;
      rs1_val_q     <= rs1_val_d;
      rd_q          <= rd_d;
      tid_q         <= tid_d;
      csr_wr_q      <= csr_wr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_we_q      <= rsp_we_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tid_q     <= rsp_tid_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) && !rst;
  assign bus.csr_raddr   = addr_q;
  assign bus.csr_waddr   = addr_q;
  // Write data is only meaningful during the strobe; it needs the old value from this cycle.
  assign bus.csr_wdata   = csr_wr_q ? new_val : '0;
  assign bus.csr_wr      = csr_wr_q;
  assign bus.csr_en      = csr_wr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_we      = rsp_we_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_tid     = rsp_tid_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_rv_csr_exec.sv
// tb/tb_rv_csr_exec.sv - scoreboard testbench for rv_csr_exec
module tb_rv_csr_exec;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TW = 3;

  typedef struct {
    logic [4:0]    rd;
    logic          we;
    logic [DW-1:0] data;
    logic [TW-1:0] tid;
    logic          ill;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_csr_exec_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW)) bus ();

  rv_csr_exec #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] csr_mem [0:4095];
  logic [DW-1:0] ref_csr [0:4095];
  logic [AW-1:0] addrs [8];
  exp_t          exp_q [$];

  int checks = 0;
  int errors = 0;
  int since_acc = 0;
  bit seen_valid = 1'b0;
  int wr_cnt = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  int hold_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CSR file: registered read, write on the strobe.
  always @(posedge clk) begin
    bus.csr_rdata <= csr_mem[bus.csr_raddr];
    if (bus.csr_wr && bus.csr_en) csr_mem[bus.csr_waddr] <= bus.csr_wdata;
  end

  always @(posedge clk) begin
    #2;
    if (hold_cnt > 0) begin
      bus.rsp_ready = 1'b0;
      hold_cnt--;
    end else begin
      bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference: architectural Zicsr semantics applied to a plain array.
  task automatic predict(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [4:0] idx,
                         input logic [DW-1:0] val, input logic [4:0] rd, input logic [TW-1:0] tid);
    exp_t e;
    logic [DW-1:0] old, op;
    bit is_none, is_rw, is_set, is_clr, wr, ill;
    old     = ref_csr[addr];
    op      = f3[2] ? DW'(idx) : val;
    is_none = (f3[1:0] == 2'd0);
    is_rw   = (f3[1:0] == 2'd1);
    is_set  = (f3[1:0] == 2'd2);
    is_clr  = (f3[1:0] == 2'd3);
    wr      = is_rw || ((is_set || is_clr) && idx != 5'd0);
    ill     = 1'b0;
`ifdef RV_CSR_EXEC_ILLEGAL_EN
    ill     = is_none || (wr && addr[11:10] == 2'b11);
`endif
    if (ill) wr = 1'b0;
    e.wdata = is_rw ? op : (is_set ? (old | op) : (old & ~op));
    e.rd    = rd;
    e.we    = (rd != 5'd0) && !ill && !is_none;
    e.data  = is_none ? '0 : old;
    e.tid   = tid;
    e.ill   = ill;
    e.wr    = wr;
    e.waddr = addr;
    if (wr) ref_csr[addr] = e.wdata;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [4:0] idx,
                       input logic [DW-1:0] val, input logic [4:0] rd, input logic [TW-1:0] tid,
                       input bit track);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      return;
    end
    bus.req_funct3   = f3;
    bus.req_csr_addr = addr;
    bus.req_rs1_idx  = idx;
    bus.req_rs1_val  = val;
    bus.req_rd       = rd;
    bus.req_tid      = tid;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    if (track) predict(f3, addr, idx, val, rd, tid);
    #1;
    bus.req_valid = 1'b0;
    since_acc  = 0;
    seen_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares the presented response every cycle it is valid, pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      wr_cnt = 0;
    end else begin
      since_acc++;
      if (bus.csr_wr) begin
        wr_cnt++;
        wr_addr = bus.csr_waddr;
        wr_data = bus.csr_wdata;
        wr_en   = bus.csr_en;
      end
      if (bus.rsp_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check("rsp_latency", 64'(since_acc), 64'd3);
        end
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check("rsp_rd", 64'(bus.rsp_rd), 64'(e.rd));
          check("rsp_we", 64'(bus.rsp_we), 64'(e.we));
          check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          check("rsp_tid", 64'(bus.rsp_tid), 64'(e.tid));
          check("rsp_illegal", 64'(bus.rsp_illegal), 64'(e.ill));
          check("req_ready_busy", 64'(bus.req_ready), 64'd0);
          if (bus.rsp_ready) begin
            check("csr_wr_count", 64'(wr_cnt), e.wr ? 64'd1 : 64'd0);
            if (e.wr && wr_cnt == 1) begin
              check("csr_waddr", 64'(wr_addr), 64'(e.waddr));
              check("csr_wdata", 64'(wr_data), 64'(e.wdata));
              check("csr_en", 64'(wr_en), 64'd1);
            end
            wr_cnt = 0;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [2:0]    f3;
    logic [4:0]    idx, rd;
    logic [AW-1:0] a;
    addrs[0] = 12'h000; addrs[1] = 12'h001; addrs[2] = 12'h300; addrs[3] = 12'h340;
    addrs[4] = 12'hC00; addrs[5] = 12'hC01; addrs[6] = 12'h7C0; addrs[7] = 12'hFFF;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = '0;
      ref_csr[i] = '0;
    end
    for (int i = 2; i < 8; i++) begin
      csr_mem[addrs[i]] = $urandom;
      ref_csr[addrs[i]] = csr_mem[addrs[i]];
    end
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_csr_addr = '0; bus.req_rs1_idx = '0;
    bus.req_rs1_val = '0; bus.req_rd = '0; bus.req_tid = '0; bus.rsp_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_csr_wr", 64'(bus.csr_wr), 64'd0);
    check("rst_csr_en", 64'(bus.csr_en), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_rsp_we", 64'(bus.rsp_we), 64'd0);
    check("rst_csr_raddr", 64'(bus.csr_raddr), 64'd0);
    check("rst_csr_wdata", 64'(bus.csr_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);

    issue(3'b001, 12'h000, 5'd1, 32'h5A, 5'd5, 3'd1, 1'b1);
    issue(3'b010, 12'h000, 5'd2, 32'h0F, 5'd0, 3'd2, 1'b1);
    issue(3'b011, 12'h000, 5'd3, 32'h0A, 5'd7, 3'd0, 1'b1);
    issue(3'b110, 12'h000, 5'd0, 32'hFFFF, 5'd9, 3'd3, 1'b1);
    wait_idle();
    check("csr0_after_rs_rc", 64'(csr_mem[0]), 64'h55);

    hold_cnt = 9;
    issue(3'b001, 12'h300, 5'd4, $urandom, 5'd3, 3'd5, 1'b1);
    issue(3'b101, 12'h340, 5'd17, 32'h0, 5'd2, 3'd6, 1'b1);
    wait_idle();

    issue(3'b001, 12'h001, 5'd1, 32'hDEADBEEF, 5'd4, 3'd1, 1'b0);
    @(posedge clk);
    #1;
    check("calc_csr_wr", 64'(bus.csr_wr), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_csr_wr", 64'(bus.csr_wr), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("dropped_write", 64'(csr_mem[1]), 64'(ref_csr[1]));

    issue(3'b001, 12'hC00, 5'd1, 32'h1234, 5'd6, 3'd2, 1'b1);
    issue(3'b000, 12'h300, 5'd5, 32'h1, 5'd8, 3'd4, 1'b1);
    issue(3'b100, 12'hC01, 5'd0, 32'h0, 5'd1, 3'd7, 1'b1);
    wait_idle();

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = addrs[$urandom_range(0, 7)];
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(f3, a, idx, $urandom, rd, 3'($urandom_range(0, 7)), 1'b1);
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      check("final_csr_value", 64'(csr_mem[addrs[i]]), 64'(ref_csr[addrs[i]]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
